// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter_if
//  Description : Bundles the fetch port, the data port and the unified memory
//                command/response bus that surround unified_mem_arbiter.
//                slave  - the arbiter's view (drives grants, responses, mem_*)
//                master - the environment's view (requesters + memory)
//  Signals     : if_req/if_addr/if_gnt/if_rvalid/if_rdata   fetch port
//                dm_req/dm_we/dm_funct3/dm_addr/dm_wdata/
//                dm_gnt/dm_rvalid/dm_rdata                  data port
//                mem_re/mem_we/mem_funct3/mem_addr/
//                mem_wdata/mem_rdata                        memory bus
//                busy                                       arbiter not idle
//  Revision    : 1.0  initial release
// ============================================================================
interface unified_mem_arbiter_if;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        dm_req;
   logic        dm_we;
   logic [2:0]  dm_funct3;
   logic [7:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   logic        mem_re;
   logic        mem_we;
   logic [2:0]  mem_funct3;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_funct3, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_re, mem_we, mem_funct3, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_funct3, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_re, mem_we, mem_funct3, mem_addr, mem_wdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter
//  Description : Shares one single-ported unified memory between instruction
//                fetch and data accesses. One access in flight at a time:
//                IDLE (accept) -> ACCESS (LAT cycles) -> RESP (1 cycle).
//                Data wins ties; after MAX_DATA_STREAK consecutive data
//                grants with fetch waiting, fetch wins the next tie.
//  Ports       : clk, rst (async, active-high)
//                bus  unified_mem_arbiter_if.slave (fetch, data, memory, busy)
//                fetch_wait_cnt, data_gnt_cnt  (only with ARB_PERF_CNT_EN)
//  Options     : `define ARB_PERF_CNT_EN adds the two performance counters
//  Revision    : 1.0  initial release
// ============================================================================
module unified_mem_arbiter #(
   parameter int LAT             = 1,
   parameter int DATA_BASE       = 84,
   parameter int MAX_DATA_STREAK = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   unified_mem_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]           fetch_wait_cnt,
   output logic [31:0]           data_gnt_cnt
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int STRK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;

   localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LAT - 1);
   localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MAX_DATA_STREAK);
   // Truncation to 8 bits gives the modulo-256 data region offset.
   localparam logic [7:0]        BASE8     = 8'(DATA_BASE);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [STRK_W-1:0] r_streak;
   logic              r_owner_dm;
   logic              r_mem_re;
   logic              r_mem_we;
   logic [2:0]        r_mem_funct3;
   logic [7:0]        r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [31:0]       r_if_rdata;
   logic [31:0]       r_dm_rdata;

   logic w_idle;
   logic w_fetch_turn;
   logic w_if_gnt;
   logic w_dm_gnt;

   // Grants are gated by rst so nothing is accepted while reset is held.
   assign w_idle       = (r_state == S_IDLE) && !rst;
   assign w_fetch_turn = (MAX_DATA_STREAK > 0) && (r_streak == STRK_MAX);
   assign w_if_gnt     = w_idle && bus.if_req && (!bus.dm_req || w_fetch_turn);
   assign w_dm_gnt     = w_idle && bus.dm_req && !(bus.if_req && w_fetch_turn);

   assign bus.if_gnt     = w_if_gnt;
   assign bus.dm_gnt     = w_dm_gnt;
   assign bus.if_rvalid  = (r_state == S_RESP) && !r_owner_dm;
   assign bus.dm_rvalid  = (r_state == S_RESP) &&  r_owner_dm;
   assign bus.if_rdata   = r_if_rdata;
   assign bus.dm_rdata   = r_dm_rdata;
   assign bus.mem_re     = r_mem_re;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_funct3 = r_mem_funct3;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.busy       = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_owner_dm   <= 1'b0;
         r_mem_re     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_funct3 <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_if_gnt) begin
                  r_owner_dm   <= 1'b0;
                  r_mem_re     <= 1'b1;
                  r_mem_we     <= 1'b0;
                  r_mem_funct3 <= 3'b010;
                  r_mem_addr   <= bus.if_addr;
                  r_cnt        <= CNT_INIT;
                  r_state      <= S_ACCESS;
               end else if (w_dm_gnt) begin
                  r_owner_dm   <= 1'b1;
                  r_mem_re     <= !bus.dm_we;
                  r_mem_we     <= bus.dm_we;
                  r_mem_funct3 <= bus.dm_funct3;
                  r_mem_addr   <= bus.dm_addr + BASE8;
                  r_mem_wdata  <= bus.dm_wdata;
                  r_cnt        <= CNT_INIT;
                  r_state      <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  // Last command cycle: memory data is valid now.
                  if (r_owner_dm) begin
                     r_dm_rdata <= r_mem_we ? 32'd0 : bus.mem_rdata;
                  end else begin
                     r_if_rdata <= bus.mem_rdata;
                  end
                  r_mem_re <= 1'b0;
                  r_mem_we <= 1'b0;
                  r_state  <= S_RESP;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Streak only evolves while requests are being sampled (IDLE).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_streak <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_if_gnt || !bus.if_req) begin
            r_streak <= '0;
         end else if (w_dm_gnt && (r_streak != STRK_MAX)) begin
            r_streak <= r_streak + STRK_W'(1);
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_wait_cnt <= '0;
         data_gnt_cnt   <= '0;
      end else begin
         if (bus.if_req && !w_if_gnt) begin
            fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
         end
         if (w_dm_gnt) begin
            data_gnt_cnt <= data_gnt_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_mem_arbiter
//  Description : Two arbiter instances (LAT=1/MAX_DATA_STREAK=2 and
//                LAT=3/MAX_DATA_STREAK=0) driven in lockstep. A transaction
//                level model predicts every output each cycle; directed
//                sequences add literal expectations, then random traffic
//                with occasional asynchronous resets follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_unified_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int max_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   // Stimulus, per instance
   logic        rst_a      [2];
   logic        if_req_a   [2];
   logic [7:0]  if_addr_a  [2];
   logic        dm_req_a   [2];
   logic        dm_we_a    [2];
   logic [2:0]  dm_f3_a    [2];
   logic [7:0]  dm_addr_a  [2];
   logic [31:0] dm_wdata_a [2];
   logic [31:0] mrd_a      [2];

   // Observed outputs, per instance
   logic        gi_o   [2];
   logic        gd_o   [2];
   logic        irv_o  [2];
   logic        drv_o  [2];
   logic [31:0] ird_o  [2];
   logic [31:0] drd_o  [2];
   logic        re_o   [2];
   logic        we_o   [2];
   logic [2:0]  f3_o   [2];
   logic [7:0]  addr_o [2];
   logic [31:0] wd_o   [2];
   logic        busy_o [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      unified_mem_arbiter_if bus ();
`ifdef ARB_PERF_CNT_EN
      logic [31:0] fwc;
      logic [31:0] dgc;
`endif
      assign bus.if_req    = if_req_a[g];
      assign bus.if_addr   = if_addr_a[g];
      assign bus.dm_req    = dm_req_a[g];
      assign bus.dm_we     = dm_we_a[g];
      assign bus.dm_funct3 = dm_f3_a[g];
      assign bus.dm_addr   = dm_addr_a[g];
      assign bus.dm_wdata  = dm_wdata_a[g];
      assign bus.mem_rdata = mrd_a[g];
      assign gi_o[g]   = bus.if_gnt;
      assign gd_o[g]   = bus.dm_gnt;
      assign irv_o[g]  = bus.if_rvalid;
      assign drv_o[g]  = bus.dm_rvalid;
      assign ird_o[g]  = bus.if_rdata;
      assign drd_o[g]  = bus.dm_rdata;
      assign re_o[g]   = bus.mem_re;
      assign we_o[g]   = bus.mem_we;
      assign f3_o[g]   = bus.mem_funct3;
      assign addr_o[g] = bus.mem_addr;
      assign wd_o[g]   = bus.mem_wdata;
      assign busy_o[g] = bus.busy;

      unified_mem_arbiter #(
         .LAT             ((g == 0) ? 1 : 3),
         .DATA_BASE       (84),
         .MAX_DATA_STREAK ((g == 0) ? 2 : 0)
      ) dut (
         .clk            (clk),
         .rst            (rst_a[g]),
         .bus            (bus)
`ifdef ARB_PERF_CNT_EN
         ,
         .fetch_wait_cnt (fwc),
         .data_gnt_cnt   (dgc)
`endif
      );
   end

   // Transaction-level model state
   bit          m_act  [2];
   int          m_t    [2];
   bit          m_dm   [2];
   bit          m_re   [2];
   bit          m_we   [2];
   logic [2:0]  m_f3   [2];
   logic [7:0]  m_addr [2];
   logic [31:0] m_wd   [2];
   logic [31:0] m_ird  [2];
   logic [31:0] m_drd  [2];
   int          m_strk [2];
   bit          e_gi   [2];
   bit          e_gd   [2];

   // Snapshots taken at the sampling point, for the directed checks
   logic        s_gi [2], s_gd [2], s_irv [2], s_drv [2], s_re [2], s_we [2], s_busy [2];
   logic [7:0]  s_addr [2];
   logic [31:0] s_wd [2], s_drd [2], s_mrd [2];

   task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL inst%0d %s cyc=%0d got=%h expected=%h", k, nm, cyc, act, exp);
      end
   endtask

   task automatic step(input int k);
      int L, M, ph;
      bit xgi, xgd, xirv, xdrv, xbusy, xre, xwe;
      L = lat_of(k);
      M = max_of(k);
      {xgi, xgd, xirv, xdrv, xbusy, xre, xwe} = '0;
      s_gi[k] = gi_o[k];   s_gd[k] = gd_o[k];   s_irv[k] = irv_o[k]; s_drv[k] = drv_o[k];
      s_re[k] = re_o[k];   s_we[k] = we_o[k];   s_busy[k] = busy_o[k];
      s_addr[k] = addr_o[k]; s_wd[k] = wd_o[k]; s_drd[k] = drd_o[k]; s_mrd[k] = mrd_a[k];
      if (rst_a[k]) begin
         m_act[k] = 0; m_strk[k] = 0; m_ird[k] = '0; m_drd[k] = '0;
         chk(k, "rst_addr", addr_o[k], 0);
         chk(k, "rst_f3", f3_o[k], 0);
         chk(k, "rst_wdata", wd_o[k], 0);
      end else if (m_act[k]) begin
         ph = cyc - m_t[k];
         xbusy = 1;
         if (ph <= L) begin
            xre = m_re[k];
            xwe = m_we[k];
            chk(k, "mem_addr", addr_o[k], m_addr[k]);
            chk(k, "mem_funct3", f3_o[k], m_f3[k]);
            if (m_dm[k]) chk(k, "mem_wdata", wd_o[k], m_wd[k]);
         end else begin
            xirv = !m_dm[k];
            xdrv = m_dm[k];
         end
      end else begin
         xgi = if_req_a[k] && (!dm_req_a[k] || (M > 0 && m_strk[k] == M));
         xgd = dm_req_a[k] && !xgi;
         if (xgi || !if_req_a[k]) m_strk[k] = 0;
         else if (xgd && m_strk[k] < M) m_strk[k] = m_strk[k] + 1;
         if (xgi) begin
            m_act[k] = 1; m_t[k] = cyc; m_dm[k] = 0;
            m_re[k] = 1; m_we[k] = 0; m_f3[k] = 3'b010; m_addr[k] = if_addr_a[k];
         end else if (xgd) begin
            m_act[k] = 1; m_t[k] = cyc; m_dm[k] = 1;
            m_re[k] = !dm_we_a[k]; m_we[k] = dm_we_a[k]; m_f3[k] = dm_f3_a[k];
            m_addr[k] = 8'((int'(dm_addr_a[k]) + 84) % 256);
            m_wd[k] = dm_wdata_a[k];
         end
      end
      chk(k, "if_gnt", gi_o[k], xgi);
      chk(k, "dm_gnt", gd_o[k], xgd);
      chk(k, "if_rvalid", irv_o[k], xirv);
      chk(k, "dm_rvalid", drv_o[k], xdrv);
      chk(k, "busy", busy_o[k], xbusy);
      chk(k, "mem_re", re_o[k], xre);
      chk(k, "mem_we", we_o[k], xwe);
      chk(k, "if_rdata", ird_o[k], m_ird[k]);
      chk(k, "dm_rdata", drd_o[k], m_drd[k]);
      if (!rst_a[k] && m_act[k] && (cyc - m_t[k] == L)) begin
         if (m_dm[k]) m_drd[k] = m_we[k] ? 32'd0 : mrd_a[k];
         else         m_ird[k] = mrd_a[k];
      end
      if (!rst_a[k] && m_act[k] && (cyc - m_t[k] == L + 1)) m_act[k] = 0;
      e_gi[k] = xgi;
      e_gd[k] = xgd;
   endtask

   task automatic tick();
      @(negedge clk);
      step(0);
      step(1);
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) mrd_a[k] = $urandom;
   endtask

   task automatic set_dm(input logic req, input logic we, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [31:0] wd);
      for (int k = 0; k < 2; k++) begin
         dm_req_a[k] = req; dm_we_a[k] = we; dm_f3_a[k] = f3;
         dm_addr_a[k] = addr; dm_wdata_a[k] = wd;
      end
   endtask

   task automatic set_if(input logic req, input logic [7:0] addr);
      for (int k = 0; k < 2; k++) begin
         if_req_a[k] = req; if_addr_a[k] = addr;
      end
   endtask

   logic [31:0] cap [2];
   int          cnt_a [2];
   int          cnt_b [2];
   logic [5:0]  code  [2];
   int          ngr   [2];
   bit          ip [2], dp [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_a[k] = 1'b1; mrd_a[k] = '0; m_act[k] = 0; m_strk[k] = 0;
         m_ird[k] = '0; m_drd[k] = '0; ip[k] = 0; dp[k] = 0;
      end
      set_if(1'b0, 8'h00);
      set_dm(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
      tick();
      tick();
      for (int k = 0; k < 2; k++) chk(k, "reset_busy", s_busy[k], 0);
      for (int k = 0; k < 2; k++) rst_a[k] = 1'b0;
      tick();

      // Load at dm_addr 0x10 -> memory address 0x64
      set_dm(1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
         chk(k, "ld_gnt", s_gd[k], 1);
         chk(k, "ld_if_gnt", s_gi[k], 0);
      end
      set_dm(1'b0, 1'b0, 3'b010, 8'h10, 32'h0);
      for (int t = 1; t <= 5; t++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if (t == 1) begin
               chk(k, "ld_addr", s_addr[k], 8'h64);
               chk(k, "ld_re", s_re[k], 1);
            end
            if (t == lat_of(k)) cap[k] = s_mrd[k];
            if (t == lat_of(k) + 1) begin
               chk(k, "ld_rvalid", s_drv[k], 1);
               chk(k, "ld_rdata", s_drd[k], cap[k]);
               chk(k, "ld_if_rvalid", s_irv[k], 0);
            end
         end
      end

      // Store at 0xC0 wraps to 0x14
      set_dm(1'b1, 1'b1, 3'b010, 8'hC0, 32'hDEADBEEF);
      tick();
      for (int k = 0; k < 2; k++) begin
         chk(k, "st_gnt", s_gd[k], 1);
         cnt_a[k] = 0;
      end
      set_dm(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
      for (int t = 1; t <= 5; t++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if (s_we[k]) cnt_a[k]++;
            if (t == 1) begin
               chk(k, "st_addr", s_addr[k], 8'h14);
               chk(k, "st_wdata", s_wd[k], 32'hDEADBEEF);
            end
            if (t == lat_of(k) + 1) begin
               chk(k, "st_rvalid", s_drv[k], 1);
               chk(k, "st_rdata", s_drd[k], 0);
            end
         end
      end
      for (int k = 0; k < 2; k++) chk(k, "st_we_cycles", cnt_a[k], lat_of(k));

      // Both requesters held: grant order D,D,F,... or data only
      set_if(1'b1, 8'h08);
      set_dm(1'b1, 1'b0, 3'b000, 8'h20, 32'h0);
      for (int k = 0; k < 2; k++) begin
         code[k] = '0; ngr[k] = 0; cnt_a[k] = 0;
      end
      for (int t = 0; t < 30; t++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if (s_gi[k]) cnt_a[k]++;
            if ((s_gi[k] || s_gd[k]) && ngr[k] < 6) begin
               code[k] = {code[k][4:0], s_gd[k]};
               ngr[k]++;
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         chk(k, "order", code[k], (k == 0) ? 6'b110110 : 6'b111111);
         chk(k, "fetch_grants", cnt_a[k], (k == 0) ? 3 : 0);
      end
      set_if(1'b0, 8'h00);
      set_dm(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
      for (int t = 0; t < 5; t++) tick();

      // Async reset during a store access
      set_dm(1'b1, 1'b1, 3'b011, 8'h30, 32'h0BAD_F00D);
      tick();
      for (int k = 0; k < 2; k++) chk(k, "ab_gnt", s_gd[k], 1);
      set_dm(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
      for (int k = 0; k < 2; k++) rst_a[k] = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         chk(k, "ab_we", s_we[k], 0);
         chk(k, "ab_busy", s_busy[k], 0);
         rst_a[k] = 1'b0;
      end
      set_dm(1'b1, 1'b0, 3'b010, 8'h40, 32'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
         chk(k, "post_rst_gnt", s_gd[k], 1);
         cnt_a[k] = 0;
      end
      set_dm(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
      for (int t = 0; t < 5; t++) begin
         tick();
         for (int k = 0; k < 2; k++) if (s_drv[k]) cnt_a[k]++;
      end
      for (int k = 0; k < 2; k++) chk(k, "post_rst_rvalids", cnt_a[k], 1);

      // Fetch timing
      set_if(1'b1, 8'h08);
      tick();
      for (int k = 0; k < 2; k++) begin
         chk(k, "f_gnt", s_gi[k], 1);
         cnt_a[k] = 0; cnt_b[k] = 0;
      end
      set_if(1'b0, 8'h00);
      for (int t = 1; t <= 5; t++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if (s_re[k]) cnt_a[k]++;
            if (s_busy[k]) cnt_b[k]++;
            if (t == lat_of(k) + 1) chk(k, "f_rvalid", s_irv[k], 1);
         end
      end
      for (int k = 0; k < 2; k++) begin
         chk(k, "f_re_cycles", cnt_a[k], lat_of(k));
         chk(k, "f_busy_cycles", cnt_b[k], lat_of(k) + 1);
      end

      // Random traffic
      for (int t = 0; t < 4000; t++) begin
         for (int k = 0; k < 2; k++) begin
            if (ip[k] && e_gi[k]) ip[k] = 0;
            else if (ip[k] && $urandom_range(0, 15) == 0) ip[k] = 0;
            if (!ip[k] && $urandom_range(0, 2) == 0) begin
               ip[k] = 1;
               if_addr_a[k] = 8'($urandom);
            end
            if (dp[k] && e_gd[k]) dp[k] = 0;
            else if (dp[k] && $urandom_range(0, 15) == 0) dp[k] = 0;
            if (!dp[k] && $urandom_range(0, 1) == 0) begin
               dp[k] = 1;
               dm_we_a[k]    = 1'($urandom);
               dm_f3_a[k]    = 3'($urandom);
               dm_addr_a[k]  = 8'($urandom);
               dm_wdata_a[k] = $urandom;
            end
            if_req_a[k] = ip[k];
            dm_req_a[k] = dp[k];
            rst_a[k]    = ($urandom_range(0, 299) == 0);
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates the single-ported unified instruction/data memory between two requesters: the instruction-fetch port (IF) and the data port (MEM stage loads/stores). It holds one outstanding access at a time and sequences the memory command for a fixed latency. It returns read data or a write acknowledge to the owning requester. Data accesses take priority, and a streak counter bounds fetch starvation.

Parameters:
LAT, 1, memory read latency in cycles from command issue to mem_rdata valid (>=1)
DATA_BASE, 84, byte offset added to data addresses (mod 256) to reach the data region
MAX_DATA_STREAK, 2, consecutive data grants allowed while fetch is waiting; 0 = strict data priority

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request
if_addr  in  8  fetch byte address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid, 1-cycle pulse
if_rdata  out  32  fetch data
dm_req  in  1  data request
dm_we  in  1  1=store, 0=load
dm_funct3  in  3  access size/sign (RISC-V funct3)
dm_addr  in  8  data byte address before DATA_BASE offset
dm_wdata  in  32  store data
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  load data valid / store done, 1-cycle pulse
dm_rdata  out  32  load data (0 for stores)
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_funct3  out  3  memory access size
mem_addr  out  8  memory byte address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state=IDLE; streak=0; all outputs 0, including mem_* command registers, rdata registers, gnt, rvalid and busy.
- Requests are sampled only in IDLE. Each requester holds req and its fields stable until gnt; req may drop after gnt.
- Selection in IDLE:
  - Only one req asserted: that requester wins.
  - Both asserted: data wins, unless MAX_DATA_STREAK>0 and streak==MAX_DATA_STREAK, in which case fetch wins.
- gnt is combinational, asserted in the IDLE cycle of acceptance only. At most one gnt per cycle.
- On accept, the command is registered:
  - Fetch: mem_re=1, mem_we=0, funct3=3'b010, addr=if_addr.
  - Data: mem_re=~dm_we, mem_we=dm_we, funct3=dm_funct3, addr=(dm_addr+DATA_BASE) mod 256 (8-bit wrap), wdata=dm_wdata.
  - State moves to ACCESS with cnt=LAT-1.
- ACCESS:
  - The command is held stable on mem_*.
  - While cnt!=0, cnt decrements.
  - At cnt==0, mem_rdata is captured into the owner's rdata register (0 for stores). mem_re and mem_we clear, then state goes to RESP.
- RESP: the owner's rvalid=1 for one cycle, rdata held until the next capture, then IDLE. There is no acceptance in RESP.
- Timing: gnt at cycle T, command on mem_* during T+1..T+LAT, rvalid at T+LAT+1. Throughput is one access per LAT+2 cycles.
- Streak counter:
  - Increments (saturating at MAX_DATA_STREAK) on a data grant while if_req=1.
  - Clears on a fetch grant, or in any IDLE cycle with if_req=0.
- Only one rvalid is ever asserted, and only the owner's.
- Stores write exactly once; mem_we is never asserted in IDLE or RESP.
- A requester dropping req without receiving gnt is legal; no access is issued for it.
- Async reset mid-ACCESS: mem_we/mem_re drop immediately, no rvalid is produced, and the aborted access is not replayed.

Optional Feature:
ARB_PERF_CNT_EN. When defined, adds outputs fetch_wait_cnt[31:0] and data_gnt_cnt[31:0], both reset to 0 and wrapping at 2^32:
- fetch_wait_cnt counts cycles with if_req=1 and if_gnt=0.
- data_gnt_cnt counts dm_gnt pulses.
When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- LAT=1, dm_req load, dm_addr=0x10, funct3=010 → dm_gnt at T, mem_addr=0x64 with mem_re=1 at T+1, dm_rvalid at T+2 with dm_rdata=mem_rdata; if_* silent.
- dm_addr=0xC0 store, wdata=0xDEADBEEF → mem_addr=0x14 (wrap), mem_we=1 for exactly 1 cycle, dm_rvalid at T+2, dm_rdata=0.
- if_req and dm_req held continuously, MAX_DATA_STREAK=2 → grant order D,D,F,D,D,F; each fetch access has mem_funct3=010, mem_we=0.
- MAX_DATA_STREAK=0, both held for 12 cycles → only data grants; if_gnt never asserted.
- LAT=3, fetch if_addr=0x08 → mem_re high for cycles T+1..T+3, if_rvalid at T+4, busy high for T+1..T+4.
- rst asserted in ACCESS of a store → mem_we low at once, no dm_rvalid, state IDLE. Next dm_req is granted on the first cycle after rst deasserts.
